// File: rtl/pwm_timer.sv
// Memory-mapped multi-channel PWM timer with a shared prescaler and counter.
// Period and duty writes land in shadow registers and reach the counter only at a wrap.
module pwm_timer #(
  parameter int unsigned CW  = 16,
  parameter int unsigned NCH = 3
) (
  input  logic           clk_24,
  input  logic           reset,
  input  logic           sel,
  input  logic [3:0]     we,
  input  logic [2:0]     addr,
  input  logic [31:0]    wdat,
  output logic [31:0]    rdat,
  output logic           rdy,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  localparam logic [2:0] AddrCtrl     = 3'd0;
  localparam logic [2:0] AddrPrescale = 3'd1;
  localparam logic [2:0] AddrPeriod   = 3'd2;
  localparam logic [2:0] AddrDuty0    = 3'd3;
  localparam logic [2:0] AddrCount    = 3'd6;
  localparam logic [2:0] AddrStatus   = 3'd7;

  logic [NCH:0]     r_ctrl;  // [0] enable, [NCH:1] per-channel invert
  logic [CW-1:0]    r_prescale;
  logic [CW-1:0]    r_prediv;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_period_sh;
  logic [CW-1:0]    r_period_act;
  logic [CW-1:0]    r_duty_sh  [NCH];
  logic [CW-1:0]    r_duty_act [NCH];
  logic             r_wrap;
  logic             r_irq_en;
  logic             r_rdy;
  logic [31:0]      r_rdat;
  logic [NCH-1:0]   r_pwm;

  logic [31:0]      w_wmask;
  logic             w_wr;
  logic             w_rd;
  logic             w_en;
  logic             w_tick;
  logic             w_wrap;
  logic [31:0]      w_rdata;
  logic [NCH-1:0]   w_raw;

  assign w_wmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign w_wr    = sel & (|we) & ~r_rdy;
  assign w_rd    = sel & ~(|we) & ~r_rdy;
  assign w_en    = r_ctrl[0];
  assign w_tick  = w_en & (r_prediv == r_prescale);
  assign w_wrap  = w_tick & (r_count == r_period_act);

  function automatic logic [CW-1:0] merge(input logic [CW-1:0] old_v, input logic [31:0] d,
                                          input logic [31:0] m);
    logic [31:0] v;
    v = (32'(old_v) & ~m) | (d & m);
    return v[CW-1:0];
  endfunction

  always_comb begin
    w_rdata = '0;
    case (addr)
      AddrCtrl:     w_rdata[NCH:0]  = r_ctrl;
      AddrPrescale: w_rdata[CW-1:0] = r_prescale;
      AddrPeriod:   w_rdata[CW-1:0] = r_period_sh;
      AddrCount:    w_rdata[CW-1:0] = r_count;
      AddrStatus:   w_rdata[1:0]    = {r_irq_en, r_wrap};
      default:      w_rdata         = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (addr == 3'(AddrDuty0 + i)) w_rdata[CW-1:0] = r_duty_sh[i];
    end
  end

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NCH; i++) w_raw[i] = w_en & (r_count < r_duty_act[i]);
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_ctrl       <= '0;
      r_prescale   <= '0;
      r_prediv     <= '0;
      r_count      <= '0;
      r_period_sh  <= '0;
      r_period_act <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
      r_wrap       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_rdy        <= 1'b0;
      r_rdat       <= '0;
      r_pwm        <= '0;
    end else begin
      r_rdy <= sel & ~r_rdy;
      if (w_rd) r_rdat <= w_rdata;

      if (w_wr) begin
        case (addr)
          AddrCtrl:     if (we[0]) r_ctrl <= wdat[NCH:0];
          AddrPrescale: r_prescale  <= merge(r_prescale, wdat, w_wmask);
          AddrPeriod:   r_period_sh <= merge(r_period_sh, wdat, w_wmask);
          AddrStatus:   if (we[0]) r_irq_en <= wdat[1];
          default:      ;
        endcase
        for (int i = 0; i < NCH; i++) begin
          if (addr == 3'(AddrDuty0 + i)) r_duty_sh[i] <= merge(r_duty_sh[i], wdat, w_wmask);
        end
      end

      // A wrap beats a same-cycle write-1-clear
      if (w_wrap) begin
        r_wrap <= 1'b1;
      end else if (w_wr && addr == AddrStatus && we[0] && wdat[0]) begin
        r_wrap <= 1'b0;
      end

      if (!w_en) begin
        r_prediv     <= '0;
        r_count      <= '0;
        r_period_act <= r_period_sh;
        for (int i = 0; i < NCH; i++) r_duty_act[i] <= r_duty_sh[i];
      end else begin
        r_prediv <= w_tick ? '0 : r_prediv + 1'b1;
        if (w_tick) r_count <= w_wrap ? '0 : r_count + 1'b1;
        // Actives take the pre-edge shadows, so a write on the wrap edge waits a period
        if (w_wrap) begin
          r_period_act <= r_period_sh;
          for (int i = 0; i < NCH; i++) r_duty_act[i] <= r_duty_sh[i];
        end
      end

      for (int i = 0; i < NCH; i++) r_pwm[i] <= w_raw[i] ^ r_ctrl[i+1];
    end
  end

  assign rdat    = r_rdat;
  assign rdy     = r_rdy;
  assign pwm_out = r_pwm;
  assign irq     = r_wrap & r_irq_en;

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboarded bench for pwm_timer: bus reads queue their expected data, a monitor
// compares on each rdy pulse; PWM/irq waveforms are checked against a cycle model.
module tb_pwm_timer;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  we;
  logic [2:0]  addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        rdy;
  logic [2:0]  pwm_out;
  logic        irq;

  pwm_timer #(.CW(16), .NCH(3)) dut (
    .clk_24  (clk_24),
    .reset   (reset),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdat    (wdat),
    .rdat    (rdat),
    .rdy     (rdy),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk_24 = ~clk_24;

  typedef struct packed {
    logic        chk;
    logic [2:0]  a;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t0;
  int   tt;
  int   j;
  logic prev_rdy = 1'b0;

  always @(posedge clk_24) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every rdy pulse consumes one scoreboard entry
  always @(negedge clk_24) begin
    exp_t e;
    if (rdy) begin
      check("rdy not back-to-back", 32'(prev_rdy), 32'h0);
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected rdy: got rdy with empty scoreboard, expected none");
      end else begin
        e = q.pop_front();
        if (e.chk) check($sformatf("read reg %0d", e.a), rdat, e.v);
      end
    end
    prev_rdy = rdy;
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] w);
    exp_t e;
    e = '{chk: 1'b0, a: a, v: 32'h0};
    q.push_back(e);
    sel = 1'b1; we = w; addr = a; wdat = d;
    @(posedge clk_24); #1;
    sel = 1'b0; we = 4'h0;
    @(posedge clk_24); #1;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] v);
    exp_t e;
    e = '{chk: 1'b1, a: a, v: v};
    q.push_back(e);
    sel = 1'b1; we = 4'h0; addr = a;
    @(posedge clk_24); #1;
    sel = 1'b0;
    @(posedge clk_24); #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk_24); #1;
    end
  endtask

  task automatic wr_at(input int c, input logic [2:0] a, input logic [31:0] d);
    wait_to(c - 1);
    bus_wr(a, d, 4'hF);
  endtask

  // Expected pwm_out k edges after enable (PRESCALE=0, PERIOD=9)
  function automatic logic [2:0] exp_pwm(input int k);
    int c, p, d;
    c = (k - 1) % 10;
    p = (k - 1) / 10;
    if (p <= 3) d = 3;
    else if (p <= 5) d = 7;
    else if (p <= 7) d = 2;
    else d = 3;
    return {1'b1, 1'b0, (c < d) ^ (k >= 79)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sel = 1'b0; we = 4'h0; addr = 3'd0; wdat = 32'h0;
    repeat (3) @(posedge clk_24);
    #1 reset = 1'b0;
    check("reset pwm_out", 32'(pwm_out), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset rdy", 32'(rdy), 32'h0);
    check("reset rdat", rdat, 32'h0);
    for (int a = 0; a < 8; a++) bus_rd(3'(a), 32'h0);

    // Four-cycle select: rdy on cycles 1 and 3 only
    q.push_back('{chk: 1'b1, a: 3'd0, v: 32'h0});
    q.push_back('{chk: 1'b1, a: 3'd0, v: 32'h0});
    sel = 1'b1; we = 4'h0; addr = 3'd0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_24); #1;
      check($sformatf("long sel rdy cycle %0d", i), 32'(rdy), 32'(i % 2));
    end
    sel = 1'b0;
    @(posedge clk_24); #1;
    check("long sel rdy after", 32'(rdy), 32'h0);
    @(posedge clk_24); #1;

    // Basic PWM, irq enabled
    bus_wr(3'd1, 32'd0, 4'hF);
    bus_wr(3'd2, 32'd9, 4'hF);
    bus_wr(3'd3, 32'd3, 4'hF);
    bus_wr(3'd4, 32'd0, 4'hF);
    bus_wr(3'd5, 32'd10, 4'hF);
    bus_wr(3'd7, 32'h2, 4'hF);
    t0 = cyc + 1;
    bus_wr(3'd0, 32'h1, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      wait_to(t0 + k);
      check($sformatf("pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k)));
      check($sformatf("irq k=%0d", k), 32'(irq), 32'(k >= 10));
    end

    // Flag clear, then clear on the wrap edge (set wins)
    wr_at(t0 + 23, 3'd7, 32'h3);
    check("irq after clear", 32'(irq), 32'h0);
    wr_at(t0 + 30, 3'd7, 32'h3);
    check("irq clear on wrap", 32'(irq), 32'h1);

    // Duty change mid-period, then on the wrap edge
    wr_at(t0 + 36, 3'd3, 32'd7);
    for (int k = 38; k <= 49; k++) begin
      wait_to(t0 + k);
      check($sformatf("pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k)));
    end
    wr_at(t0 + 50, 3'd3, 32'd2);
    for (int k = 52; k <= 72; k++) begin
      wait_to(t0 + k);
      check($sformatf("pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k)));
    end

    // Restore duty 3, invert channel 0
    wr_at(t0 + 73, 3'd3, 32'd3);
    wr_at(t0 + 78, 3'd0, 32'h3);
    for (int k = 81; k <= 100; k++) begin
      wait_to(t0 + k);
      check($sformatf("pwm inv k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k)));
    end
    bus_rd(3'd3, 32'd3);
    bus_rd(3'd2, 32'd9);
    bus_rd(3'd0, 32'h3);
    bus_rd(3'd7, 32'h3);

    // Prescaled run: PRESCALE=2, PERIOD=1
    bus_wr(3'd0, 32'h0, 4'hF);
    bus_wr(3'd7, 32'h3, 4'hF);
    check("irq cleared while disabled", 32'(irq), 32'h0);
    bus_wr(3'd1, 32'd2, 4'hF);
    bus_wr(3'd2, 32'd1, 4'hF);
    tt = cyc + 1;
    bus_wr(3'd0, 32'h1, 4'hF);
    for (int i = 0; i < 7; i++) begin
      j = cyc - tt;
      if (i == 2 || i == 3) bus_rd(3'd7, 32'(2 | ((j >= 6) ? 1 : 0)));
      else bus_rd(3'd6, 32'((j / 3) % 2));
    end

    // Reset in the middle of a read: no rdy for it
    sel = 1'b1; we = 4'h0; addr = 3'd6; reset = 1'b1;
    @(posedge clk_24); #1;
    reset = 1'b0; sel = 1'b0;
    check("mid reset rdy", 32'(rdy), 32'h0);
    check("mid reset pwm_out", 32'(pwm_out), 32'h0);
    check("mid reset irq", 32'(irq), 32'h0);
    @(posedge clk_24); #1;
    bus_rd(3'd6, 32'h0);
    bus_rd(3'd7, 32'h0);
    bus_rd(3'd0, 32'h0);
    bus_rd(3'd2, 32'h0);

    // Byte lanes and read-only COUNT
    bus_wr(3'd1, 32'h1234, 4'h1);
    bus_rd(3'd1, 32'h34);
    bus_wr(3'd1, 32'hAB00, 4'h2);
    bus_rd(3'd1, 32'hAB34);
    bus_wr(3'd2, 32'hFFFF_0000, 4'hC);
    bus_rd(3'd2, 32'h0);
    bus_wr(3'd6, 32'hFFFF, 4'hF);
    bus_rd(3'd6, 32'h0);

    repeat (3) @(posedge clk_24);
    #1;
    check("scoreboard drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
